// File: rtl/axi_pkg.sv
// Shared types for the AXI SRAM responder.
// Response codes, responder FSM states, arbitration priority.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_t;

  typedef enum logic {
    PRIO_RD,
    PRIO_WR
  } prio_t;

endpackage

// File: rtl/axi_if.sv
// AXI4 single-beat bus bundle.
// Modports: in (subordinate side), out (initiator side).
interface axi_if;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport in (
    input  arvalid, araddr, arid, arlen,
    input  arsize, arburst, rready,
    input  awvalid, awaddr, awid, awlen,
    input  awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    output arready, rvalid, rdata, rresp,
    output rlast, rid,
    output awready, wready,
    output bvalid, bresp, bid
  );

  modport out (
    output arvalid, araddr, arid, arlen,
    output arsize, arburst, rready,
    output awvalid, awaddr, awid, awlen,
    output awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    input  arready, rvalid, rdata, rresp,
    input  rlast, rid,
    input  awready, wready,
    input  bvalid, bresp, bid
  );

endinterface

// File: rtl/axi_sram_array.sv
// Single-port 32-bit SRAM, byte enables, synchronous read.
// Ports: clock, en, we, be, addr (word), wdata, rdata (registered).
module axi_sram_array #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-3:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**(ADDR_W-2)];

  // Writes leave rdata alone so a pending read word stays stable.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_sram_resp.sv
// AXI4 single-beat SRAM responder, one transaction at a time.
// Ports: clock, reset (sync, high), mem_r (AR/R), mem_w (AW/W/B).
module axi_sram_resp
  import axi_pkg::*;
#(
  parameter int          ADDR_W = 16,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          LAT    = 2
) (
  input  logic clock,
  input  logic reset,
  axi_if.in    mem_r,
  axi_if.in    mem_w
);

  state_t      state_q, state_d;
  prio_t       prio_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [3:0]  id_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        want_rd, want_wr, idle;
  logic        gnt_rd, gnt_wr;
  logic        ar_rdy, aw_rdy, w_rdy;
  logic        ar_hs, aw_hs, w_hs;
  logic        wr_fire, rd_fire, w_ok;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_strb;
  logic [31:0] arr_rdata;

  function automatic logic in_range(logic [31:0] a);
    logic [32:0] lo, hi;
    lo = {1'b0, BASE};
    hi = lo + (33'd1 << ADDR_W);
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  assign want_rd = mem_r.arvalid;
  assign want_wr = mem_w.awvalid | mem_w.wvalid;
  assign idle    = (state_q == IDLE) && !reset;
  assign gnt_rd  = idle && want_rd &&
                   (!want_wr || prio_q == PRIO_RD);
  assign gnt_wr  = idle && want_wr && !gnt_rd;

  assign ar_rdy = gnt_rd;
  assign aw_rdy = gnt_wr ||
                  (state_q == WR_ADDR && !reset);
  assign w_rdy  = gnt_wr ||
                  (state_q == WR_DATA && !reset);

  assign ar_hs = mem_r.arvalid && ar_rdy;
  assign aw_hs = mem_w.awvalid && aw_rdy;
  assign w_hs  = mem_w.wvalid && w_rdy;

  // Completes when the later of AW and W handshakes lands.
  assign wr_fire = (aw_hs || state_q == WR_DATA) &&
                   (w_hs || state_q == WR_ADDR);
  assign rd_fire = (state_q == RD_WAIT) && (cnt_q == 4'd0);

  assign w_addr = (state_q == WR_DATA) ? addr_q : mem_w.awaddr;
  assign w_data = (state_q == WR_ADDR) ? wdata_q : mem_w.wdata;
  assign w_strb = (state_q == WR_ADDR) ? wstrb_q : mem_w.wstrb;
  assign w_ok   = in_range(w_addr);

  axi_sram_array #(.ADDR_W(ADDR_W)) u_array (
    .clock (clock),
    .en    (rd_fire | (wr_fire & w_ok)),
    .we    (wr_fire),
    .be    (w_strb),
    .addr  (rd_fire ? addr_q[ADDR_W-1:2] : w_addr[ADDR_W-1:2]),
    .wdata (w_data),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs)        state_d = RD_WAIT;
        else if (wr_fire) state_d = WR_RESP;
        else if (aw_hs)   state_d = WR_DATA;
        else if (w_hs)    state_d = WR_ADDR;
      end
      RD_WAIT: if (cnt_q == 4'd0) state_d = RD_RESP;
      RD_RESP: if (mem_r.rready)  state_d = IDLE;
      WR_ADDR: if (aw_hs)         state_d = WR_RESP;
      WR_DATA: if (w_hs)          state_d = WR_RESP;
      WR_RESP: if (mem_w.bready)  state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= PRIO_RD;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (idle && want_rd && want_wr)
        prio_q <= gnt_rd ? PRIO_WR : PRIO_RD;
      if (ar_hs)
        cnt_q <= 4'(LAT);
      else if (state_q == RD_WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (ar_hs) begin
      addr_q <= mem_r.araddr;
      id_q   <= mem_r.arid;
      err_q  <= !in_range(mem_r.araddr);
    end
    if (aw_hs) begin
      addr_q <= mem_w.awaddr;
      id_q   <= mem_w.awid;
    end
    if (w_hs) begin
      wdata_q <= mem_w.wdata;
      wstrb_q <= mem_w.wstrb;
    end
    if (wr_fire) err_q <= !w_ok;
  end

  assign mem_r.arready = ar_rdy;
  assign mem_r.rvalid  = (state_q == RD_RESP);
  assign mem_r.rlast   = (state_q == RD_RESP);
  assign mem_r.rdata   = err_q ? 32'd0 : arr_rdata;
  assign mem_r.rresp   = err_q ? RESP_DECERR : RESP_OKAY;
  assign mem_r.rid     = id_q;
  assign mem_r.awready = 1'b0;
  assign mem_r.wready  = 1'b0;
  assign mem_r.bvalid  = 1'b0;
  assign mem_r.bresp   = RESP_OKAY;
  assign mem_r.bid     = 4'd0;

  assign mem_w.awready = aw_rdy;
  assign mem_w.wready  = w_rdy;
  assign mem_w.bvalid  = (state_q == WR_RESP);
  assign mem_w.bresp   = err_q ? RESP_DECERR : RESP_OKAY;
  assign mem_w.bid     = id_q;
  assign mem_w.arready = 1'b0;
  assign mem_w.rvalid  = 1'b0;
  assign mem_w.rlast   = 1'b0;
  assign mem_w.rdata   = 32'd0;
  assign mem_w.rresp   = RESP_OKAY;
  assign mem_w.rid     = 4'd0;

  logic unused_ok;
  assign unused_ok = ^{
    mem_r.arsize, mem_r.arlen, mem_r.arburst,
    mem_r.awvalid, mem_r.awaddr, mem_r.awid,
    mem_r.awlen, mem_r.awsize, mem_r.awburst,
    mem_r.wvalid, mem_r.wdata, mem_r.wstrb,
    mem_r.wlast, mem_r.bready,
    mem_w.awsize, mem_w.awlen, mem_w.awburst,
    mem_w.wlast, mem_w.arvalid, mem_w.araddr,
    mem_w.arid, mem_w.arlen, mem_w.arsize,
    mem_w.arburst, mem_w.rready
  };

  // Only single-beat INCR-less traffic is supported.
  ar_single: assert property (
    @(posedge clock) disable iff (reset)
    ar_hs |-> (mem_r.arlen == 8'd0 &&
               mem_r.arburst == 2'd0));

  aw_single: assert property (
    @(posedge clock) disable iff (reset)
    aw_hs |-> (mem_w.awlen == 8'd0 &&
               mem_w.awburst == 2'd0));

endmodule

// File: tb/tb_axi_sram_resp.sv
// Directed bench for axi_sram_resp (LAT=2, ADDR_W=16).
// Drives both AXI bundles, checks with immediate assertions.
module tb_axi_sram_resp;
  import axi_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  axi_if r_bus();
  axi_if w_bus();

  axi_sram_resp #(
    .ADDR_W (16),
    .BASE   (32'h8000_0000),
    .LAT    (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .mem_r (r_bus),
    .mem_w (w_bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic wait_b(output logic [1:0] resp,
                        output logic [3:0] id);
    logic ok;
    ok = 1'b0;
    resp = 2'bx;
    id = 4'bx;
    w_bus.bready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      mid();
      if (w_bus.bvalid) begin
        ok = 1'b1;
        resp = w_bus.bresp;
        id = w_bus.bid;
      end
      tick();
    end
    w_bus.bready = 1'b0;
    chk("b_done", 32'(ok), 32'd1);
  endtask

  task automatic wait_r(output logic [31:0] data,
                        output logic [1:0] resp,
                        output logic [3:0] id);
    logic ok;
    ok = 1'b0;
    data = 32'bx;
    resp = 2'bx;
    id = 4'bx;
    r_bus.rready = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      mid();
      if (r_bus.rvalid) begin
        ok = 1'b1;
        data = r_bus.rdata;
        resp = r_bus.rresp;
        id = r_bus.rid;
      end
      tick();
    end
    r_bus.rready = 1'b0;
    chk("r_done", 32'(ok), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s,
                    input logic [3:0] id,
                    output logic [1:0] resp);
    logic ad, wd;
    logic [3:0] bid;
    ad = 1'b0;
    wd = 1'b0;
    w_bus.awaddr = a;
    w_bus.awid = id;
    w_bus.wdata = d;
    w_bus.wstrb = s;
    w_bus.awvalid = 1'b1;
    w_bus.wvalid = 1'b1;
    for (int i = 0; i < 20 && !(ad && wd); i++) begin
      mid();
      if (w_bus.awvalid && w_bus.awready) ad = 1'b1;
      if (w_bus.wvalid && w_bus.wready) wd = 1'b1;
      tick();
      if (ad) w_bus.awvalid = 1'b0;
      if (wd) w_bus.wvalid = 1'b0;
    end
    w_bus.awvalid = 1'b0;
    w_bus.wvalid = 1'b0;
    chk("wr_accept", 32'(ad && wd), 32'd1);
    wait_b(resp, bid);
    chk("wr_bid", 32'(bid), 32'(id));
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [3:0] id,
                    output logic [31:0] data,
                    output logic [1:0] resp);
    logic ad;
    logic [3:0] rid;
    ad = 1'b0;
    r_bus.araddr = a;
    r_bus.arid = id;
    r_bus.arvalid = 1'b1;
    for (int i = 0; i < 20 && !ad; i++) begin
      mid();
      if (r_bus.arvalid && r_bus.arready) ad = 1'b1;
      tick();
      if (ad) r_bus.arvalid = 1'b0;
    end
    r_bus.arvalid = 1'b0;
    chk("rd_accept", 32'(ad), 32'd1);
    wait_r(data, resp, rid);
    chk("rd_rid", 32'(rid), 32'(id));
  endtask

  logic [31:0] d;
  logic [1:0]  rs;
  logic [3:0]  id;
  logic        seen;

  initial begin
    r_bus.arvalid = 0; r_bus.araddr = 0; r_bus.arid = 0;
    r_bus.arlen = 0; r_bus.arsize = 3'd2; r_bus.arburst = 0;
    r_bus.rready = 0;
    r_bus.awvalid = 0; r_bus.awaddr = 0; r_bus.awid = 0;
    r_bus.awlen = 0; r_bus.awsize = 0; r_bus.awburst = 0;
    r_bus.wvalid = 0; r_bus.wdata = 0; r_bus.wstrb = 0;
    r_bus.wlast = 0; r_bus.bready = 0;
    w_bus.arvalid = 0; w_bus.araddr = 0; w_bus.arid = 0;
    w_bus.arlen = 0; w_bus.arsize = 0; w_bus.arburst = 0;
    w_bus.rready = 0;
    w_bus.awvalid = 0; w_bus.awaddr = 0; w_bus.awid = 0;
    w_bus.awlen = 0; w_bus.awsize = 3'd2; w_bus.awburst = 0;
    w_bus.wvalid = 0; w_bus.wdata = 0; w_bus.wstrb = 0;
    w_bus.wlast = 1; w_bus.bready = 0;

    // Reset: readies stay low even with requests pending.
    tick();
    r_bus.arvalid = 1;
    w_bus.awvalid = 1;
    w_bus.wvalid = 1;
    mid();
    chk("rst_arready", 32'(r_bus.arready), 0);
    chk("rst_awready", 32'(w_bus.awready), 0);
    chk("rst_wready", 32'(w_bus.wready), 0);
    chk("rst_rvalid", 32'(r_bus.rvalid), 0);
    chk("rst_bvalid", 32'(w_bus.bvalid), 0);
    tick();
    r_bus.arvalid = 0;
    w_bus.awvalid = 0;
    w_bus.wvalid = 0;
    tick();
    reset = 0;

    // Same-cycle AW+W, bvalid one cycle later.
    w_bus.awaddr = 32'h8000_0010;
    w_bus.awid = 4'h3;
    w_bus.wdata = 32'hDEAD_BEEF;
    w_bus.wstrb = 4'hF;
    w_bus.awvalid = 1;
    w_bus.wvalid = 1;
    mid();
    chk("t1_awready", 32'(w_bus.awready), 1);
    chk("t1_wready", 32'(w_bus.wready), 1);
    chk("t1_bvalid_c0", 32'(w_bus.bvalid), 0);
    tick();
    w_bus.awvalid = 0;
    w_bus.wvalid = 0;
    w_bus.bready = 1;
    mid();
    chk("t1_bvalid", 32'(w_bus.bvalid), 1);
    chk("t1_bresp", 32'(w_bus.bresp), 0);
    chk("t1_bid", 32'(w_bus.bid), 32'h3);
    tick();
    w_bus.bready = 0;
    mid();
    chk("t1_bvalid_end", 32'(w_bus.bvalid), 0);
    tick();

    // Read with LAT=2: rvalid in cycle 4.
    r_bus.araddr = 32'h8000_0010;
    r_bus.arid = 4'h5;
    r_bus.arvalid = 1;
    mid();
    chk("t1_arready", 32'(r_bus.arready), 1);
    tick();
    r_bus.arvalid = 0;
    for (int c = 1; c < 4; c++) begin
      mid();
      chk("t1_rvalid_early", 32'(r_bus.rvalid), 0);
      tick();
    end
    mid();
    chk("t1_rvalid", 32'(r_bus.rvalid), 1);
    chk("t1_rdata", r_bus.rdata, 32'hDEAD_BEEF);
    chk("t1_rresp", 32'(r_bus.rresp), 0);
    chk("t1_rlast", 32'(r_bus.rlast), 1);
    chk("t1_rid", 32'(r_bus.rid), 32'h5);
    r_bus.rready = 1;
    tick();
    r_bus.rready = 0;
    mid();
    chk("t1_rvalid_end", 32'(r_bus.rvalid), 0);
    tick();

    // Partial byte-lane write.
    wr(32'h8000_0020, 32'h1122_3344, 4'hF, 4'h1, rs);
    chk("t2_bresp0", 32'(rs), 0);
    wr(32'h8000_0022, 32'h00AB_0000, 4'b0100, 4'h2, rs);
    chk("t2_bresp1", 32'(rs), 0);
    rd(32'h8000_0020, 4'h3, d, rs);
    chk("t2_merge", d, 32'h11AB_3344);

    // AW first, W three cycles later; AR blocked meanwhile.
    w_bus.awaddr = 32'h8000_0030;
    w_bus.awid = 4'h7;
    w_bus.awvalid = 1;
    mid();
    chk("t3_awready", 32'(w_bus.awready), 1);
    tick();
    w_bus.awvalid = 0;
    r_bus.araddr = 32'h8000_0010;
    r_bus.arid = 4'h2;
    r_bus.arvalid = 1;
    mid();
    chk("t3_state", 32'(dut.state_q), 32'(WR_DATA));
    chk("t3_awready_c1", 32'(w_bus.awready), 0);
    chk("t3_wready_c1", 32'(w_bus.wready), 1);
    chk("t3_arready_c1", 32'(r_bus.arready), 0);
    tick();
    mid();
    chk("t3_arready_c2", 32'(r_bus.arready), 0);
    tick();
    w_bus.wdata = 32'hCAFE_F00D;
    w_bus.wstrb = 4'hF;
    w_bus.wvalid = 1;
    mid();
    chk("t3_wready_c3", 32'(w_bus.wready), 1);
    chk("t3_arready_c3", 32'(r_bus.arready), 0);
    tick();
    w_bus.wvalid = 0;
    w_bus.bready = 1;
    mid();
    chk("t3_bvalid_c4", 32'(w_bus.bvalid), 1);
    chk("t3_bid", 32'(w_bus.bid), 32'h7);
    chk("t3_arready_c4", 32'(r_bus.arready), 0);
    tick();
    w_bus.bready = 0;
    mid();
    chk("t3_bvalid_c5", 32'(w_bus.bvalid), 0);
    chk("t3_arready_c5", 32'(r_bus.arready), 1);
    tick();
    r_bus.arvalid = 0;
    wait_r(d, rs, id);
    chk("t3_rdata", d, 32'hDEAD_BEEF);
    chk("t3_rid", 32'(id), 32'h2);
    rd(32'h8000_0030, 4'h4, d, rs);
    chk("t3_readback", d, 32'hCAFE_F00D);

    // Round-robin after a fresh reset.
    reset = 1;
    tick();
    tick();
    reset = 0;
    r_bus.araddr = 32'h8000_0030;
    r_bus.arid = 4'h1;
    r_bus.arvalid = 1;
    w_bus.awaddr = 32'h8000_0040;
    w_bus.awid = 4'h4;
    w_bus.wdata = 32'h0102_0304;
    w_bus.wstrb = 4'hF;
    w_bus.awvalid = 1;
    w_bus.wvalid = 1;
    mid();
    chk("t4_arready", 32'(r_bus.arready), 1);
    chk("t4_awready", 32'(w_bus.awready), 0);
    chk("t4_wready", 32'(w_bus.wready), 0);
    tick();
    r_bus.arvalid = 0;
    mid();
    chk("t4_awready_busy", 32'(w_bus.awready), 0);
    tick();
    wait_r(d, rs, id);
    chk("t4_rdata", d, 32'hCAFE_F00D);
    chk("t4_rid", 32'(id), 32'h1);
    mid();
    chk("t4_wr_after", 32'(w_bus.awready), 1);
    tick();
    w_bus.awvalid = 0;
    w_bus.wvalid = 0;
    wait_b(rs, id);
    chk("t4_bid", 32'(id), 32'h4);
    r_bus.araddr = 32'h8000_0040;
    r_bus.arid = 4'h6;
    r_bus.arvalid = 1;
    w_bus.awaddr = 32'h8000_0044;
    w_bus.awid = 4'h8;
    w_bus.wdata = 32'hA5A5_A5A5;
    w_bus.awvalid = 1;
    w_bus.wvalid = 1;
    mid();
    chk("t4b_awready", 32'(w_bus.awready), 1);
    chk("t4b_wready", 32'(w_bus.wready), 1);
    chk("t4b_arready", 32'(r_bus.arready), 0);
    tick();
    w_bus.awvalid = 0;
    w_bus.wvalid = 0;
    wait_b(rs, id);
    chk("t4b_bid", 32'(id), 32'h8);
    mid();
    chk("t4b_arready_after", 32'(r_bus.arready), 1);
    tick();
    r_bus.arvalid = 0;
    wait_r(d, rs, id);
    chk("t4b_rdata", d, 32'h0102_0304);
    chk("t4b_rid", 32'(id), 32'h6);
    rd(32'h8000_0044, 4'h0, d, rs);
    chk("t4b_readback", d, 32'hA5A5_A5A5);

    // Address decode boundaries and DECERR.
    wr(32'h8000_0000, 32'h55AA_55AA, 4'hF, 4'h1, rs);
    chk("t5_base_bresp", 32'(rs), 0);
    rd(32'h9000_0000, 4'h2, d, rs);
    chk("t5_oor_rresp", 32'(rs), 32'h3);
    chk("t5_oor_rdata", d, 32'h0);
    wr(32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 4'h3, rs);
    chk("t5_oor_bresp", 32'(rs), 32'h3);
    wr(32'h9000_0010, 32'hFFFF_FFFF, 4'hF, 4'h3, rs);
    chk("t5_oor_bresp2", 32'(rs), 32'h3);
    rd(32'h8001_0000, 4'h4, d, rs);
    chk("t5_past_end", 32'(rs), 32'h3);
    rd(32'h7FFF_FFFC, 4'h5, d, rs);
    chk("t5_below_base", 32'(rs), 32'h3);
    wr(32'h8000_FFFC, 32'h0BAD_F00D, 4'hF, 4'h6, rs);
    chk("t5_top_bresp", 32'(rs), 0);
    rd(32'h8000_FFFC, 4'h7, d, rs);
    chk("t5_top_rresp", 32'(rs), 0);
    chk("t5_top_rdata", d, 32'h0BAD_F00D);
    rd(32'h8000_0000, 4'h8, d, rs);
    chk("t5_word0", d, 32'h55AA_55AA);
    rd(32'h8000_0010, 4'h9, d, rs);
    chk("t5_word10", d, 32'hDEAD_BEEF);

    // Stall in RD_RESP, then reset mid-response.
    r_bus.araddr = 32'h8000_0020;
    r_bus.arid = 4'h9;
    r_bus.arvalid = 1;
    mid();
    chk("t6_arready", 32'(r_bus.arready), 1);
    tick();
    r_bus.arvalid = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (r_bus.rvalid) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("t6_rvalid_seen", 32'(seen), 1);
    chk("t6_rdata_c0", r_bus.rdata, 32'h11AB_3344);
    tick();
    mid();
    chk("t6_rvalid_c1", 32'(r_bus.rvalid), 1);
    chk("t6_rdata_c1", r_bus.rdata, 32'h11AB_3344);
    tick();
    reset = 1;
    mid();
    chk("t6_rdata_c2", r_bus.rdata, 32'h11AB_3344);
    tick();
    reset = 0;
    mid();
    chk("t6_rvalid_rst", 32'(r_bus.rvalid), 0);
    chk("t6_bvalid_rst", 32'(w_bus.bvalid), 0);
    tick();

    // Half-collected write dropped by reset.
    w_bus.awaddr = 32'h8000_0020;
    w_bus.awid = 4'h2;
    w_bus.awvalid = 1;
    mid();
    chk("t6_aw_only", 32'(w_bus.awready), 1);
    tick();
    w_bus.awvalid = 0;
    mid();
    chk("t6_wr_data", 32'(dut.state_q), 32'(WR_DATA));
    tick();
    reset = 1;
    w_bus.wdata = 32'hFFFF_FFFF;
    w_bus.wstrb = 4'hF;
    w_bus.wvalid = 1;
    mid();
    chk("t6_wready_rst", 32'(w_bus.wready), 0);
    tick();
    w_bus.wvalid = 0;
    reset = 0;
    mid();
    chk("t6_idle", 32'(dut.state_q), 32'(IDLE));
    tick();
    rd(32'h8000_0020, 4'hA, d, rs);
    chk("t6_retained", d, 32'h11AB_3344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
